// File: rtl/window_3x3_if.sv
// Pixel-stream input and 3x3 window output bundle for window_3x3_gen.
// The window generator uses the slave view; the pixel source / window consumer uses master.
interface window_3x3_if #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned ColW = $clog2(IMG_W);

    // Input pixel stream
    logic            in_valid;
    logic            in_ready;
    logic [23:0]     in_rgb;

    // Output window, one-cycle pulse per window, no backpressure
    logic            out_valid;
    logic [23:0]     out_rgb;
    logic [7:0]      top;
    logic [7:0]      bot;
    logic [7:0]      left;
    logic [7:0]      right;
    logic [7:0]      top_left;
    logic [7:0]      top_right;
    logic [7:0]      bot_left;
    logic [7:0]      bot_right;
    logic [RowW-1:0] out_row;
    logic [ColW-1:0] out_col;
    logic            out_eof;

    modport master (
        output in_valid, in_rgb,
        input  in_ready,
        input  out_valid, out_rgb, top, bot, left, right,
        input  top_left, top_right, bot_left, bot_right,
        input  out_row, out_col, out_eof
    );

    modport slave (
        input  in_valid, in_rgb,
        output in_ready,
        output out_valid, out_rgb, top, bot, left, right,
        output top_left, top_right, bot_left, bot_right,
        output out_row, out_col, out_eof
    );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood window generator for a raster-order RGB stream.
// Conceptually a (2*IMG_W+3)-pixel delay line: the newest pixel is the bottom-right neighbour
// and the pixel IMG_W+1 places back is the centre. Two IMG_W-deep line buffers provide the
// row delays; small registers supply the adjacent-column taps. Neighbours carry green only.
// Edge neighbours are zeroed from the centre's (row, col), so stale line-buffer data and
// data from the adjacent row never reach the outputs.
module window_3x3_gen #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input logic        clk,
    input logic        reset,
    window_3x3_if.slave bus
);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned CntW = $clog2(IMG_W * IMG_H + 1);

    typedef enum logic [1:0] {StFill, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] k_q, k_d;          // index of the next pixel to be accepted
    logic [CntW-1:0] drain_q, drain_d;  // drain cycles already issued
    logic [ColW-1:0] ptr_q;             // shared line-buffer read/write address
    logic [RowW-1:0] win_row_q;
    logic [ColW-1:0] win_col_q;

    // Line buffers: lb0 delays the full pixel by one row, lb1 delays its green by another row
    logic [23:0]     lb0_mem [IMG_W];
    logic [7:0]      lb1_mem [IMG_W];
    logic [23:0]     lb0_rd;
    logic [7:0]      lb1_rd;

    // Column taps: b* bottom row, m* centre row, t* top row
    logic [7:0]      b0_q, b1_q;
    logic [23:0]     m0_q;
    logic [7:0]      m1_q;
    logic [7:0]      t0_q, t1_q;

    logic            accept;
    logic            shift;
    logic            emit;
    logic            eof;
    logic [23:0]     new_px;
    logic            has_top, has_bot, has_left, has_right;

    assign bus.in_ready = (state_q != StDrain);
    assign accept       = bus.in_valid & bus.in_ready;

    assign lb0_rd = lb0_mem[ptr_q];
    assign lb1_rd = lb1_mem[ptr_q];

    assign has_top   = (win_row_q != '0);
    assign has_bot   = (win_row_q != RowW'(IMG_H - 1));
    assign has_left  = (win_col_q != '0);
    assign has_right = (win_col_q != ColW'(IMG_W - 1));

    // Next-state: frame sequencing, delay-line shift and window emission
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        shift   = 1'b0;
        emit    = 1'b0;
        eof     = 1'b0;
        new_px  = 24'h0;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    shift  = 1'b1;
                    new_px = bus.in_rgb;
                    k_d    = k_q + 1'b1;
                    // Pixel (1,1) completes the first window's bottom-right neighbour
                    if (k_q == CntW'(IMG_W + 1)) begin
                        emit    = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    shift  = 1'b1;
                    new_px = bus.in_rgb;
                    emit   = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == CntW'(IMG_W * IMG_H - 1)) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                // Push zero pixels through to flush the last IMG_W+1 windows
                shift   = 1'b1;
                emit    = 1'b1;
                drain_d = drain_q + 1'b1;
                if (drain_q == CntW'(IMG_W)) begin
                    eof     = 1'b1;
                    state_d = StFill;
                    k_d     = '0;
                    drain_d = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Control state and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
            k_q     <= '0;
            drain_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            if (shift) begin
                ptr_q <= (ptr_q == ColW'(IMG_W - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    // Line buffer storage; read-before-write at ptr gives an exact IMG_W-shift delay
    always_ff @(posedge clk) begin
        if (shift) begin
            lb0_mem[ptr_q] <= new_px;
            lb1_mem[ptr_q] <= lb0_rd[15:8];
        end
    end

    // Column tap registers
    always_ff @(posedge clk) begin
        if (reset) begin
            b0_q <= '0;
            b1_q <= '0;
            m0_q <= '0;
            m1_q <= '0;
            t0_q <= '0;
            t1_q <= '0;
        end else if (shift) begin
            b0_q <= new_px[15:8];
            b1_q <= b0_q;
            m0_q <= lb0_rd;
            m1_q <= m0_q[15:8];
            t0_q <= lb1_rd;
            t1_q <= t0_q;
        end
    end

    // Centre position of the window about to be emitted
    always_ff @(posedge clk) begin
        if (reset) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (emit) begin
            if (win_col_q == ColW'(IMG_W - 1)) begin
                win_col_q <= '0;
                win_row_q <= (win_row_q == RowW'(IMG_H - 1)) ? '0 : win_row_q + 1'b1;
            end else begin
                win_col_q <= win_col_q + 1'b1;
            end
        end
    end

    // Registered window outputs; taps are read before this edge's shift, so the new pixel
    // is bottom-right and the centre is the pixel IMG_W+1 places back
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.out_rgb   <= '0;
            bus.top       <= '0;
            bus.bot       <= '0;
            bus.left      <= '0;
            bus.right     <= '0;
            bus.top_left  <= '0;
            bus.top_right <= '0;
            bus.bot_left  <= '0;
            bus.bot_right <= '0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else begin
            bus.out_valid <= emit;
            bus.out_eof   <= eof;
            if (emit) begin
                bus.out_rgb   <= m0_q;
                bus.top_left  <= (has_top && has_left)  ? t1_q          : 8'h00;
                bus.top       <= has_top                ? t0_q          : 8'h00;
                bus.top_right <= (has_top && has_right) ? lb1_rd        : 8'h00;
                bus.left      <= has_left               ? m1_q          : 8'h00;
                bus.right     <= has_right              ? lb0_rd[15:8]  : 8'h00;
                bus.bot_left  <= (has_bot && has_left)  ? b1_q          : 8'h00;
                bus.bot       <= has_bot                ? b0_q          : 8'h00;
                bus.bot_right <= (has_bot && has_right) ? new_px[15:8]  : 8'h00;
                bus.out_row   <= win_row_q;
                bus.out_col   <= win_col_q;
            end
        end
    end
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen at IMG_W=4, IMG_H=3.
// Pixel (r,c) has G = base + 4r + c + 1 and R = B = 8'hAA.
module tb_window_3x3_gen;
    localparam int unsigned W = 4;
    localparam int unsigned H = 3;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  tl, t, tr, l, r, bl, b, br;
        logic [1:0]  row, col;
        logic        eof;
    } win_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    win_t exp_q[$];

    window_3x3_if #(.IMG_W(W), .IMG_H(H)) bus ();

    window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] green(int r, int c, int base);
        if (r < 0 || r >= int'(H) || c < 0 || c >= int'(W)) return 8'h00;
        return 8'(base + 4 * r + c + 1);
    endfunction

    function automatic win_t exp_win(int n, int base);
        win_t w;
        int r = n / int'(W);
        int c = n % int'(W);
        w.rgb = {8'hAA, green(r, c, base), 8'hAA};
        w.tl  = green(r - 1, c - 1, base);
        w.t   = green(r - 1, c,     base);
        w.tr  = green(r - 1, c + 1, base);
        w.l   = green(r,     c - 1, base);
        w.r   = green(r,     c + 1, base);
        w.bl  = green(r + 1, c - 1, base);
        w.b   = green(r + 1, c,     base);
        w.br  = green(r + 1, c + 1, base);
        w.row = 2'(r);
        w.col = 2'(c);
        w.eof = (n == int'(W * H) - 1);
        return w;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every output window is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            win_t act;
            win_t req;
            act = '{rgb: bus.out_rgb, tl: bus.top_left, t: bus.top, tr: bus.top_right,
                    l: bus.left, r: bus.right, bl: bus.bot_left, b: bus.bot,
                    br: bus.bot_right, row: bus.out_row, col: bus.out_col, eof: bus.out_eof};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window: got %h expected none", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL window(%0d,%0d): got %h expected %h",
                             req.row, req.col, act, req);
                end
            end
        end
    end

    // Offer one pixel and hold it until accepted (bounded)
    task automatic send(logic [23:0] px);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_rgb   = px;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Stream npx pixels of a frame, pushing the windows each accepted pixel releases
    task automatic run_frame(int base, bit gaps, int npx);
        for (int n = 0; n < npx; n++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                @(posedge clk); #1;
            end
            send({8'hAA, green(n / int'(W), n % int'(W), base), 8'hAA});
            if (n >= int'(W) + 1) exp_q.push_back(exp_win(n - int'(W) - 1, base));
            if (n == int'(W * H) - 1) begin
                for (int m = n - int'(W); m < int'(W * H); m++) exp_q.push_back(exp_win(m, base));
                for (int i = 0; i < int'(W) + 1; i++) begin
                    chk("drain_in_ready_low", 64'(bus.in_ready), 64'd0);
                    @(posedge clk); #1;
                end
                chk("in_ready_after_drain", 64'(bus.in_ready), 64'd1);
            end
        end
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_rgb   = 24'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_eof", 64'(bus.out_eof), 64'd0);
        chk("reset_out_rgb", 64'(bus.out_rgb), 64'd0);
        chk("reset_neigh", {bus.top_left, bus.top, bus.top_right, bus.left,
                            bus.right, bus.bot_left, bus.bot, bus.bot_right}, 64'd0);
        chk("reset_index", 64'({bus.out_row, bus.out_col}), 64'd0);

        // Continuous frame
        run_frame(0, 1'b0, W * H);
        wait_empty();

        // Same frame with random input gaps
        run_frame(0, 1'b1, W * H);
        wait_empty();

        // Partial frame then reset
        run_frame(0, 1'b0, 7);
        @(posedge clk); #1;
        wait_empty();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("after_reset_quiet", 64'(bus.out_valid), 64'd0);
        end
        run_frame(0, 1'b0, W * H);
        wait_empty();

        // Two back-to-back frames, second offset by 100
        run_frame(0, 1'b0, W * H);
        run_frame(100, 1'b0, W * H);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
